alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Executes all RV32I ALU operations plus the RV32M multiply/divide/remainder set.
- Simple ops return a registered result in 1 cycle; MUL*/DIV*/REM* run on a shared iterative radix-2 datapath.
- Sits in the execute stage; the stage stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- SHW, $clog2(XLEN), shift-amount width; derived, do not override.
- ITER_CYC, XLEN, iterations per MUL/DIV; derived.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill any in-flight op (branch mispredict or trap).
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept an op this cycle.
- op  in  5  operation code; values from the alu_pkg constants.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2 or immediate).
- shamt  in  SHW  pre-shift for ADD_SFT.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  result.
- out_err  out  1  op was not a legal code; qualified by out_valid.

Behaviour:
- Op codes:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, ADD_SFT=10.
  - MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - All other codes are illegal.
- Shift operations use b[SHW-1:0] only. SRA is its own code; bit 30 of b is not decoded. ADD_SFT = a + (b << shamt), truncated to XLEN.
- State machine (IDLE, BUSY, DONE):
  - Reset: IDLE; out_valid=0, result=0, out_err=0, internal counter=0.
  - in_ready = !flush && (IDLE || (DONE && out_ready)).
  - Accept when in_valid && in_ready.
  - Simple op, illegal op, or MUL/DIV special case → DONE next cycle. Out_valid rises at acceptance cycle + 1.
  - MUL*/DIV*/REM* → BUSY for ITER_CYC cycles, then DONE. Out_valid rises at acceptance cycle + ITER_CYC + 1.
  - DONE with out_ready and no new accept → IDLE.
  - DONE with out_ready and a new accept → back-to-back: next result or BUSY. No bubble for simple ops.
  - DONE with !out_ready: result and out_err held stable. in_ready=0.
- Multiply: unsigned shift-add on magnitudes, 2·XLEN product, sign fixed at the end.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned semantics respectively.
- Divide: restoring divide on magnitudes.
  - Quotient sign = sa^sb; remainder sign = sa.
  - Divide by zero: quotient = all-ones, remainder = a. Takes the 1-cycle path.
  - Signed overflow (a = MIN, b = −1): DIV = MIN, REM = 0. Takes the 1-cycle path.
- Illegal op: result = 0, out_err = 1, 1-cycle latency.
- Flush has priority over everything: any state → IDLE next cycle, out_valid=0, no op accepted in the flush cycle.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded.
- Input operands are captured at acceptance; a/b/op may change afterwards.

Optional Feature:
- Macro: ALU_MUL_FAST_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single combinational XLEN×XLEN multiplier and take the 1-cycle path. DIV/REM remain iterative.
- Undefined: all M ops are iterative, and the multiplier is not instantiated.
- Results are identical in both builds; only latency differs.

Decomposition:
- alu_pkg (shared with decode):
  - Op code localparams ALU_ADD … ALU_REMU.
  - State encodings ST_IDLE/ST_BUSY/ST_DONE.
  - Helper functions is_muldiv(op) and is_legal(op).
- One sub-module, muldiv_iter: owns the shift registers, counter and sign fix-up. Interface is start / done / result.
- Simple ops live in the top level's combinational case statement.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 → 0x80000000, out_valid one cycle after accept. SRA a=0x80000000, b=0x21 → 0xC0000000 (shift 1). ADD_SFT a=4, b=3, shamt=2 → 16.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MUL result arrives at accept + 33 with the macro off, accept + 1 with it on.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000, REM → 0. DIVU a=5, b=0 → 0xFFFFFFFF, REMU → 5. All four at 1-cycle latency.
- Hold out_ready=0 for 5 cycles after DIV 100/7=14 → result held at 14, in_ready=0. Release out_ready with a new ADD pending → ADD accepted the same cycle.
- Assert flush at cycle 10 of a DIVU → out_valid never rises for it, IDLE next cycle. Pulse rst_n low mid-MUL → all outputs return to 0 asynchronously.
- op=31 → result=0, out_err=1, out_valid one cycle after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, control-state encodings and op-class helpers.
package alu_pkg;

    localparam logic [4:0] ALU_ADD     = 5'd0;
    localparam logic [4:0] ALU_SUB     = 5'd1;
    localparam logic [4:0] ALU_SLL     = 5'd2;
    localparam logic [4:0] ALU_SLT     = 5'd3;
    localparam logic [4:0] ALU_SLTU    = 5'd4;
    localparam logic [4:0] ALU_XOR     = 5'd5;
    localparam logic [4:0] ALU_SRL     = 5'd6;
    localparam logic [4:0] ALU_SRA     = 5'd7;
    localparam logic [4:0] ALU_OR      = 5'd8;
    localparam logic [4:0] ALU_AND     = 5'd9;
    localparam logic [4:0] ALU_ADD_SFT = 5'd10;
    localparam logic [4:0] ALU_MUL     = 5'd16;
    localparam logic [4:0] ALU_MULH    = 5'd17;
    localparam logic [4:0] ALU_MULHSU  = 5'd18;
    localparam logic [4:0] ALU_MULHU   = 5'd19;
    localparam logic [4:0] ALU_DIV     = 5'd20;
    localparam logic [4:0] ALU_DIVU    = 5'd21;
    localparam logic [4:0] ALU_REM     = 5'd22;
    localparam logic [4:0] ALU_REMU    = 5'd23;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // M-extension ops occupy codes 16..23.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return (op <= ALU_ADD_SFT) || is_muldiv(op);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 engine shared by multiply (shift-add) and divide (restoring), on magnitudes with final sign fix-up.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ITER_CYC = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER_CYC);

    logic            busy_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] opd_r;
    logic            is_div_r;
    logic            sel_r;
    logic            neg_r;

    logic            sa_s;
    logic            sb_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   diff_s;
    logic [XLEN-1:0] hi_n_s;
    logic [XLEN-1:0] lo_n_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] val_s;

    // Operand sign decode and magnitudes for the op being started.
    always_comb begin
        sa_s    = a[XLEN-1] & ((op == ALU_MULH) || (op == ALU_MULHSU) ||
                               (op == ALU_DIV)  || (op == ALU_REM));
        sb_s    = b[XLEN-1] & ((op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM));
        mag_a_s = sa_s ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
        mag_b_s = sb_s ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;
    end

    // One iteration step; hi holds partial product / remainder, lo holds multiplier / quotient.
    always_comb begin
        sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(XLEN+1){1'b0}});
        diff_s = {hi_r, lo_r[XLEN-1]} - {1'b0, opd_r};
        if (is_div_r) begin
            if (!diff_s[XLEN]) begin
                hi_n_s = diff_s[XLEN-1:0];
                lo_n_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_n_s = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
                lo_n_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n_s = sum_s[XLEN:1];
            lo_n_s = {sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the final step so the result is ready on the done cycle.
    always_comb begin
        prod_s = {hi_n_s, lo_n_s};
        val_s  = sel_r ? hi_n_s : lo_n_s;
        if (neg_r) begin
            prod_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
            val_s  = ~val_s + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_s = {hi_n_s, lo_n_s};
        end
        if (is_div_r) begin
            result = val_s;
        end else begin
            result = sel_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    assign done = busy_r && (cnt_r == CW'(ITER_CYC - 1));

    // Engine state: load on start, step while busy, stop on done or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            cnt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            opd_r    <= '0;
            is_div_r <= 1'b0;
            sel_r    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (abort) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= '0;
            hi_r     <= '0;
            is_div_r <= op[2];
            if (op[2]) begin
                lo_r  <= mag_a_s;
                opd_r <= mag_b_s;
                sel_r <= op[1];
                neg_r <= op[1] ? sa_s : (sa_s ^ sb_s);
            end else begin
                lo_r  <= mag_b_s;
                opd_r <= mag_a_s;
                sel_r <= (op[1:0] != 2'b00);
                neg_r <= sa_s ^ sb_s;
            end
        end else if (busy_r) begin
            hi_r  <= hi_n_s;
            lo_r  <= lo_n_s;
            if (done) begin
                busy_r <= 1'b0;
                cnt_r  <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Handshaked RV32I/RV32M ALU: single-cycle simple ops, iterative MUL/DIV/REM.
// Define ALU_MUL_FAST_EN to run MUL* through a one-cycle combinational multiplier.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SHW      = $clog2(XLEN),
    parameter int ITER_CYC = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [SHW-1:0]  shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_err
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_r;
    logic            valid_r;
    logic [XLEN-1:0] result_r;
    logic            err_r;

    logic            accept_s;
    logic [SHW-1:0]  sh_s;
    logic [XLEN-1:0] simple_res_s;
    logic            div_op_s;
    logic            b_zero_s;
    logic            ovf_s;
    logic            fast_mul_s;
    logic            one_cycle_s;
    logic [XLEN-1:0] next_res_s;
    logic            iter_start_s;
    logic            iter_done_s;
    logic [XLEN-1:0] iter_res_s;

    assign in_ready  = !flush && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready));
    assign accept_s  = in_valid && in_ready;
    assign out_valid = valid_r;
    assign result    = result_r;
    assign out_err   = err_r;
    assign sh_s      = b[SHW-1:0];

    // Single-cycle RV32I datapath.
    always_comb begin
        simple_res_s = '0;
        case (op)
            ALU_ADD:     simple_res_s = a + b;
            ALU_SUB:     simple_res_s = a - b;
            ALU_SLL:     simple_res_s = a << sh_s;
            ALU_SLT:     simple_res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:    simple_res_s = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:     simple_res_s = a ^ b;
            ALU_SRL:     simple_res_s = a >> sh_s;
            ALU_SRA:     simple_res_s = $signed(a) >>> sh_s;
            ALU_OR:      simple_res_s = a | b;
            ALU_AND:     simple_res_s = a & b;
            ALU_ADD_SFT: simple_res_s = a + (b << shamt);
            default:     simple_res_s = '0;
        endcase
    end

`ifdef ALU_MUL_FAST_EN
    logic signed [XLEN:0]     fa_s;
    logic signed [XLEN:0]     fb_s;
    logic        [2*XLEN-1:0] fprod_s;

    // Sign-extend each operand per MULH/MULHSU/MULHU semantics; low 2*XLEN bits are exact.
    always_comb begin
        fa_s       = {a[XLEN-1] & ((op == ALU_MULH) || (op == ALU_MULHSU)), a};
        fb_s       = {b[XLEN-1] & (op == ALU_MULH), b};
        fprod_s    = (2*XLEN)'(fa_s) * (2*XLEN)'(fb_s);
        fast_mul_s = is_muldiv(op) && !op[2];
    end
`else
    assign fast_mul_s = 1'b0;
`endif

    // Divide special cases and selection of the one-cycle result.
    always_comb begin
        div_op_s    = is_muldiv(op) && op[2];
        b_zero_s    = (b == '0);
        ovf_s       = ((op == ALU_DIV) || (op == ALU_REM)) && (a == MIN_VAL) && (b == '1);
        one_cycle_s = !is_legal(op) || !is_muldiv(op) ||
                      (div_op_s && (b_zero_s || ovf_s)) || fast_mul_s;
        next_res_s  = '0;
        if (!is_legal(op)) begin
            next_res_s = '0;
        end else if (!is_muldiv(op)) begin
            next_res_s = simple_res_s;
        end else if (div_op_s && b_zero_s) begin
            next_res_s = op[1] ? a : '1;
        end else if (div_op_s && ovf_s) begin
            next_res_s = op[1] ? '0 : MIN_VAL;
        end else begin
`ifdef ALU_MUL_FAST_EN
            next_res_s = (op == ALU_MUL) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
`else
            next_res_s = '0;
`endif
        end
    end

    assign iter_start_s = accept_s && !one_cycle_s;

    muldiv_iter #(
        .XLEN     (XLEN),
        .ITER_CYC (ITER_CYC)
    ) u_muldiv_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .abort  (flush),
        .start  (iter_start_s),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (iter_done_s),
        .result (iter_res_s)
    );

    // Control FSM and registered outputs; flush overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            valid_r  <= 1'b0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
        end else if (accept_s) begin
            if (one_cycle_s) begin
                state_r  <= ST_DONE;
                valid_r  <= 1'b1;
                result_r <= next_res_s;
                err_r    <= !is_legal(op);
            end else begin
                state_r <= ST_BUSY;
                valid_r <= 1'b0;
                err_r   <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_BUSY: begin
                    if (iter_done_s) begin
                        state_r  <= ST_DONE;
                        valid_r  <= 1'b1;
                        result_r <= iter_res_s;
                        err_r    <= 1'b0;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: arithmetic reference model plus scoreboard on every output cycle.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit rand_rdy = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          due;
        bit          seen;
    } exp_t;
    exp_t q[$];

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {err, result} straight from the RV32I/M arithmetic rules.
    function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] s);
        logic [63:0] p;
        logic [31:0] r;
        logic        e;
        e = 1'b0;
        r = 32'd0;
        p = 64'd0;
        case (o)
            5'd0:  r = x + y;
            5'd1:  r = x - y;
            5'd2:  r = x << y[4:0];
            5'd3:  r = {31'd0, ($signed(x) < $signed(y))};
            5'd4:  r = {31'd0, (x < y)};
            5'd5:  r = x ^ y;
            5'd6:  r = x >> y[4:0];
            5'd7:  r = $signed(x) >>> y[4:0];
            5'd8:  r = x | y;
            5'd9:  r = x & y;
            5'd10: r = x + (y << s);
            5'd16, 5'd17: begin
                p = 64'($signed(x)) * 64'($signed(y));
                r = (o == 5'd16) ? p[31:0] : p[63:32];
            end
            5'd18: begin
                p = 64'($signed(x)) * {32'd0, y};
                r = p[63:32];
            end
            5'd19: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[63:32];
            end
            5'd20: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = 32'($signed(x) / $signed(y));
            end
            5'd21: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            5'd22: begin
                if (y == 32'd0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'($signed(x) % $signed(y));
            end
            5'd23: r = (y == 32'd0) ? x : x % y;
            default: begin
                e = 1'b1;
                r = 32'd0;
            end
        endcase
        return {e, r};
    endfunction

    function automatic int lat_of(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= 5'd16 && o <= 5'd19) begin
`ifdef ALU_MUL_FAST_EN
            return 1;
`else
            return 33;
`endif
        end else if (o >= 5'd20 && o <= 5'd23) begin
            if (y == 32'd0) return 1;
            if ((o == 5'd20 || o == 5'd22) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    // Scoreboard: check every valid output cycle, then record newly accepted ops.
    initial forever begin
        logic [32:0] m;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !q[0].seen && cyc > q[0].due && !out_valid) begin
                checks++;
                fails++;
                $display("FAIL latency: no out_valid by cycle %0d, required at cycle %0d", cyc, q[0].due);
                q[0].seen = 1;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL spurious_valid: out_valid=1 with no op outstanding, result %h (cycle %0d)", result, cyc);
                end else begin
                    if (!q[0].seen) begin
                        chk("latency", 32'(cyc), 32'(q[0].due));
                        q[0].seen = 1;
                    end
                    chk("result", result, q[0].res);
                    chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                m = model(op, a, b, shamt);
                q.push_back('{res: m[31:0], err: m[32], due: cyc + lat_of(op, a, b), seen: 0});
            end
        end
    end

    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s, output int tries);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        shamt = s;
        tries = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            tries++;
            if (tries > 300) begin
                checks++;
                fails++;
                $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", o);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                checks++;
                fails++;
                $display("FAIL drain_timeout: %0d results outstanding", q.size());
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t;
        logic [32:0] m;
        logic [4:0] o;
        logic [31:0] x;
        logic [31:0] y;

        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 5'd0;
        a = 32'd0;
        b = 32'd0;
        shamt = 5'd0;
        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_out_err", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Hand-computed pins on the model itself.
        m = model(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        chk("model_mulh", m[31:0], 32'h0000_0000);
        m = model(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        chk("model_mulhu", m[31:0], 32'hFFFF_FFFE);
        m = model(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        chk("model_div_ovf", m[31:0], 32'h8000_0000);
        m = model(5'd23, 32'd5, 32'd0, 5'd0);
        chk("model_remu_by0", m[31:0], 32'd5);
        m = model(5'd7, 32'h8000_0000, 32'h21, 5'd0);
        chk("model_sra", m[31:0], 32'hC000_0000);
        m = model(5'd10, 32'd4, 32'd3, 5'd2);
        chk("model_add_sft", m[31:0], 32'd16);
        m = model(5'd31, 32'd1, 32'd2, 5'd0);
        chk("model_illegal", {31'd0, m[32]}, 32'd1);
        m = model(5'd22, 32'hFFFF_FFF9, 32'd2, 5'd0);
        chk("model_rem_sign", m[31:0], 32'hFFFF_FFFF);

        // Directed test-plan ops through the DUT.
        @(posedge clk);
        #1;
        send(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, t);
        send(5'd7, 32'h8000_0000, 32'h21, 5'd0, t);
        send(5'd10, 32'd4, 32'd3, 5'd2, t);
        send(5'd31, 32'h1234, 32'h5678, 5'd0, t);
        send(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, t);
        send(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, t);
        send(5'd16, 32'd12345, 32'hFFFF_FFF0, 5'd0, t);
        send(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, t);
        send(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, t);
        send(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, t);
        send(5'd21, 32'd5, 32'd0, 5'd0, t);
        send(5'd23, 32'd5, 32'd0, 5'd0, t);
        send(5'd20, 32'hFFFF_FF9C, 32'd7, 5'd0, t);
        send(5'd22, 32'd100, 32'hFFFF_FFF9, 5'd0, t);
        drain();

        // Back-pressure: DIV 100/7 held for 5 cycles with an ADD pending.
        out_ready = 1'b0;
        send(5'd20, 32'd100, 32'd7, 5'd0, t);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op = 5'd0;
        a = 32'd40;
        b = 32'd2;
        shamt = 5'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", result, 32'd14);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(5'd0, 32'd40, 32'd2, 5'd0, t);
        chk("release_same_cycle_accept", 32'(t), 32'd0);
        drain();

        // Flush at cycle 10 of a DIVU, with a new op offered in the flush cycle.
        send(5'd21, 32'hDEAD_BEEF, 32'd3, 5'd0, t);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        op = 5'd0;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_flush_idle", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a MUL.
        send(5'd0, 32'd5, 32'd6, 5'd0, t);
        drain();
        send(5'd16, 32'h0001_0003, 32'h0000_0007, 5'd0, t);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_out_err", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic with random consumer back-pressure.
        rand_rdy = 1;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: o = 5'($urandom_range(0, 10));
                5, 6, 7, 8:    o = 5'($urandom_range(16, 23));
                default:       o = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(11, 15))
                                                               : 5'($urandom_range(24, 31));
            endcase
            x = pick();
            y = pick();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(o, x, y, 5'($urandom), t);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

endmodule
